// File: rtl/if_fetch_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
package if_fetch_pkg;

    localparam logic        RST_ENABLE   = 1'b0;
    localparam int          INST_ADDR_W  = 32;
    localparam int          INST_DATA_W  = 32;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_HOLD = 2'd2,
        FETCH_DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_skid_buf.sv
// One-entry pc+instruction holding register that catches a read completing under stall.
module if_skid_buf
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int INST_W = INST_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              unload,
    input  logic              clear,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [INST_W-1:0] inst_in,
    output logic              full,
    output logic [ADDR_W-1:0] pc_out,
    output logic [INST_W-1:0] inst_out
);

    logic              full_q, full_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;

    always_comb begin
        full_d = full_q;
        pc_d   = pc_q;
        inst_d = inst_q;
        // clear (redirect) beats a simultaneous load
        if (clear || unload) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d = 1'b1;
            pc_d   = pc_in;
            inst_d = inst_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            full_q <= 1'b0;
            pc_q   <= '0;
            inst_q <= '0;
        end else begin
            full_q <= full_d;
            pc_q   <= pc_d;
            inst_q <= inst_d;
        end
    end

    assign full     = full_q;
    assign pc_out   = pc_q;
    assign inst_out = inst_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the memory req/ack handshake and
// presents pc/inst/valid to the IF/ID register, honouring stall and branch redirect.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int          ADDR_W   = INST_ADDR_W,
    parameter int          INST_W   = INST_DATA_W,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INST_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              if_valid
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(PC_STEP);
    localparam logic [INST_W-1:0] BUBBLE = INST_W'(ZERO_WORD);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [INST_W-1:0] if_inst_q, if_inst_d;
    logic              if_valid_q, if_valid_d;

    logic              skid_load, skid_unload, skid_clear, skid_full;
    logic [ADDR_W-1:0] skid_pc;
    logic [INST_W-1:0] skid_inst;
    logic              acked;

    assign mem_req = (state_q == FETCH_REQ) || (state_q == FETCH_DROP);
    assign acked   = mem_req && mem_ack;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mem_addr_d  = mem_addr_q;
        if_pc_d     = if_pc_q;
        if_inst_d   = if_inst_q;
        if_valid_d  = if_valid_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;

        case (state_q)
            FETCH_IDLE: begin
                state_d    = FETCH_REQ;
                mem_addr_d = pc_q;
            end
            FETCH_REQ: begin
                if (acked) begin
                    pc_d       = pc_q + STEP;
                    mem_addr_d = pc_q + STEP;
                    // IF/ID not accepting: park the word and stop requesting
                    if (stall) begin
                        skid_load = 1'b1;
                        state_d   = FETCH_HOLD;
                    end
                end
            end
            FETCH_HOLD: begin
                if (!stall) begin
                    skid_unload = 1'b1;
                    state_d     = FETCH_REQ;
                    mem_addr_d  = pc_q;
                end
            end
            FETCH_DROP: begin
                if (acked) begin
                    state_d    = FETCH_REQ;
                    mem_addr_d = pc_q;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase

        if (!stall) begin
            if (skid_full) begin
                if_pc_d    = skid_pc;
                if_inst_d  = skid_inst;
                if_valid_d = 1'b1;
            end else if (state_q == FETCH_REQ && acked) begin
                if_pc_d    = mem_addr_q;
                if_inst_d  = mem_rdata;
                if_valid_d = 1'b1;
            end else begin
                if_inst_d  = BUBBLE;
                if_valid_d = 1'b0;
            end
        end

        // Redirect overrides stall and any same-cycle ack; an unacked read
        // must still complete with its address unchanged, so it is dropped.
        if (branch_flag) begin
            pc_d        = branch_target;
            skid_clear  = 1'b1;
            skid_load   = 1'b0;
            skid_unload = 1'b0;
            if_pc_d     = if_pc_q;
            if_inst_d   = BUBBLE;
            if_valid_d  = 1'b0;
            if (mem_req && !acked) begin
                state_d    = FETCH_DROP;
                mem_addr_d = mem_addr_q;
            end else begin
                state_d    = FETCH_REQ;
                mem_addr_d = branch_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= RST_PC;
            mem_addr_q <= RST_PC;
            if_pc_q    <= '0;
            if_inst_q  <= BUBBLE;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
        end
    end

    if_skid_buf #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .unload   (skid_unload),
        .clear    (skid_clear),
        .pc_in    (mem_addr_q),
        .inst_in  (mem_rdata),
        .full     (skid_full),
        .pc_out   (skid_pc),
        .inst_out (skid_inst)
    );

    assign mem_addr = mem_addr_q;
    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;
    assign if_valid = if_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: zero-wait, slow memory, stall/skid, redirects, async reset.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    logic        auto_ack;
    logic        man_ack;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    // instruction word is a fixed function of its address
    assign mem_ack   = auto_ack ? mem_req : man_ack;
    assign mem_rdata = mem_addr + 32'h1000_0000;

    if_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_valid      (if_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                           input logic vld);
        chk({tag, ".if_pc"},    if_pc,           pc);
        chk({tag, ".if_inst"},  if_inst,         inst);
        chk({tag, ".if_valid"}, {31'b0, if_valid}, {31'b0, vld});
    endtask

    task automatic chk_mem(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, ".mem_req"},  {31'b0, mem_req}, {31'b0, req});
        chk({tag, ".mem_addr"}, mem_addr,         addr);
    endtask

    // pulse reset low between clock edges
    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; branch_flag = 1'b0; branch_target = 32'h0;
        auto_ack = 1'b0; man_ack = 1'b0;
        #3;
        chk_out("rst", 32'h0, 32'h0, 1'b0);
        chk_mem("rst", 1'b0, 32'h0);

        // 1: zero-wait memory
        auto_ack = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        chk_mem("t1.c1", 1'b1, 32'h0);
        chk_out("t1.c1", 32'h0, 32'h0, 1'b0);
        tick(); chk_out("t1.c2", 32'h0, 32'h1000_0000, 1'b1);
        tick(); chk_out("t1.c3", 32'h4, 32'h1000_0004, 1'b1);
        tick(); chk_out("t1.c4", 32'h8, 32'h1000_0008, 1'b1);
        tick(); chk_out("t1.c5", 32'hC, 32'h1000_000C, 1'b1);

        // 2: slow memory, ack on the third cycle of the request
        auto_ack = 1'b0;
        do_reset();
        tick();
        man_ack = 1'b1;
        tick(); chk_out("t2.a0", 32'h0, 32'h1000_0000, 1'b1);
        chk_mem("t2.a0", 1'b1, 32'h4);
        man_ack = 1'b0;
        tick(); chk_out("t2.w1", 32'h0, 32'h0, 1'b0);
        chk_mem("t2.w1", 1'b1, 32'h4);
        tick(); chk_mem("t2.w2", 1'b1, 32'h4);
        chk_out("t2.w2", 32'h0, 32'h0, 1'b0);
        man_ack = 1'b1;
        tick(); chk_out("t2.a4", 32'h4, 32'h1000_0004, 1'b1);
        chk_mem("t2.a4", 1'b1, 32'h8);
        man_ack = 1'b0;
        tick(); chk_out("t2.gap", 32'h4, 32'h0, 1'b0);

        // 3: stall with valid output while the read of 0xC completes
        man_ack = 1'b1;
        tick(); chk_out("t3.a8", 32'h8, 32'h1000_0008, 1'b1);
        man_ack = 1'b0; stall = 1'b1;
        tick(); chk_out("t3.st", 32'h8, 32'h1000_0008, 1'b1);
        chk_mem("t3.st", 1'b1, 32'hC);
        man_ack = 1'b1;
        tick(); chk_out("t3.hold", 32'h8, 32'h1000_0008, 1'b1);
        chk({"t3.hold", ".mem_req"}, {31'b0, mem_req}, 32'h0);
        man_ack = 1'b0;
        tick(); chk({"t3.hold2", ".mem_req"}, {31'b0, mem_req}, 32'h0);
        chk_out("t3.hold2", 32'h8, 32'h1000_0008, 1'b1);
        stall = 1'b0;
        tick(); chk_out("t3.skid", 32'hC, 32'h1000_000C, 1'b1);
        chk_mem("t3.resume", 1'b1, 32'h10);

        // 4: redirect to 0x100 in the cycle 0x8 is acked
        do_reset();
        tick();
        man_ack = 1'b1;
        tick(); chk_out("t4.a0", 32'h0, 32'h1000_0000, 1'b1);
        tick(); chk_out("t4.a4", 32'h4, 32'h1000_0004, 1'b1);
        chk_mem("t4.a4", 1'b1, 32'h8);
        branch_flag = 1'b1; branch_target = 32'h100;
        tick(); chk_out("t4.br", 32'h4, 32'h0, 1'b0);
        chk_mem("t4.br", 1'b1, 32'h100);
        branch_flag = 1'b0; man_ack = 1'b0;
        tick(); chk_out("t4.w", 32'h4, 32'h0, 1'b0);
        man_ack = 1'b1;
        tick(); chk_out("t4.tgt", 32'h100, 32'h1000_0100, 1'b1);
        man_ack = 1'b0;

        // 5: redirect to 0x200 while the read of 0x104 is outstanding
        tick(); chk_mem("t5.o1", 1'b1, 32'h104);
        branch_flag = 1'b1; branch_target = 32'h200;
        tick(); chk_mem("t5.drop", 1'b1, 32'h104);
        chk_out("t5.drop", 32'h100, 32'h0, 1'b0);
        branch_flag = 1'b0;
        tick(); chk_mem("t5.o3", 1'b1, 32'h104);
        man_ack = 1'b1;
        tick(); chk_mem("t5.ack", 1'b1, 32'h200);
        chk_out("t5.ack", 32'h100, 32'h0, 1'b0);
        tick(); chk_out("t5.tgt", 32'h200, 32'h1000_0200, 1'b1);
        man_ack = 1'b0;

        // 6: asynchronous reset between edges during a request
        chk_mem("t6.pre", 1'b1, 32'h204);
        #2;
        rst = 1'b0;
        #1;
        chk_mem("t6.async", 1'b0, 32'h0);
        chk_out("t6.async", 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        tick(); chk_mem("t6.post", 1'b1, 32'h0);
        man_ack = 1'b1;
        tick(); chk_out("t6.a0", 32'h0, 32'h1000_0000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
